lcd_status_display: RTL and testbench

//  Parametrised successor to the fixed-format LCD status writer. Renders "Cmd:X B:<dir> D:<dist>" onto
//  the 16x2 character LCD by issuing an instruction stream to the LCD_Controller Avalon-MM slave.

---
 rtl/lcd_pkg.sv | 31 +++
 rtl/lcd_status_display_if.sv | 24 ++
 rtl/lcd_bin2bcd.sv | 61 ++++++
 rtl/lcd_status_display.sv | 184 ++++++++++++++++++
 tb/tb_lcd_status_display.sv | 277 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/lcd_pkg.sv
// Shared constants and types for the LCD status display: controller instructions,
// ASCII glyphs and the frame sequencer state encoding.
package lcd_pkg;

  localparam logic [7:0] CLEAR_DISPLAY = 8'h01;
  localparam logic [7:0] CURSOR_OFF    = 8'h0C;

  localparam logic [7:0] CHR_C       = 8'h43;
  localparam logic [7:0] CHR_LOWER_M = 8'h6D;
  localparam logic [7:0] CHR_LOWER_D = 8'h64;
  localparam logic [7:0] CHR_COLON   = 8'h3A;
  localparam logic [7:0] CHR_SPACE   = 8'h20;
  localparam logic [7:0] CHR_B       = 8'h42;
  localparam logic [7:0] CHR_D       = 8'h44;
  localparam logic [7:0] CHR_HASH    = 8'h23;
  localparam logic [7:0] CHR_0       = 8'h30;

  typedef enum logic [2:0] {
    StIdle,
    StConvert,
    StClear,
    StCursor,
    StChars,
    StDone
  } state_e;

  function automatic logic [7:0] digit_char(input logic [3:0] d);
    return CHR_0 + {4'h0, d};
  endfunction

endpackage

// File: rtl/lcd_status_display_if.sv
// Avalon-MM write channel towards the LCD_Controller slave.
interface lcd_status_display_if;

  logic       address;
  logic       chipselect;
  logic       byteenable;
  logic       read;
  logic       write;
  logic       waitrequest;
  logic [7:0] readdata;
  logic [1:0] response;
  logic [7:0] writedata;

  modport master (
    output address, chipselect, byteenable, read, write, writedata,
    input  waitrequest, readdata, response
  );

  modport slave (
    input  address, chipselect, byteenable, read, write, writedata,
    output waitrequest, readdata, response
  );

endinterface

// File: rtl/lcd_bin2bcd.sv
// Sequential double-dabble: one bit per cycle, done W cycles after start.
// overflow flags values that do not fit in DIGITS decimal digits.
module lcd_bin2bcd #(
  parameter int unsigned W      = 8,
  parameter int unsigned DIGITS = 3
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  start,
  input  logic [W-1:0]          value,
  output logic                  done,
  output logic [4*DIGITS-1:0]   bcd,
  output logic                  overflow
);

  localparam int unsigned CNT_W = $clog2(W + 1);
  localparam int unsigned BCD_W = 4 * DIGITS;

  function automatic int unsigned pow10(input int unsigned n);
    int unsigned r = 1;
    for (int unsigned i = 0; i < n; i++) r = r * 10;
    return r;
  endfunction

  localparam int unsigned MAX = pow10(DIGITS) - 1;

  logic [BCD_W-1:0] bcd_q, adj;
  logic [W-1:0]     bin_q;
  logic [CNT_W-1:0] cnt_q;
  logic             ovf_q;

  always_comb begin
    adj = bcd_q;
    for (int i = 0; i < int'(DIGITS); i++) begin
      if (bcd_q[4*i +: 4] >= 4'd5) adj[4*i +: 4] = bcd_q[4*i +: 4] + 4'd3;
    end
  end

  // The load cycle already performs the first shift (no add-3 is possible on zero digits).
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      bcd_q <= '0;
      bin_q <= '0;
      cnt_q <= '0;
      ovf_q <= 1'b0;
    end else if (start) begin
      bcd_q <= BCD_W'(value[W-1]);
      bin_q <= value << 1;
      cnt_q <= CNT_W'(W - 1);
      ovf_q <= 32'(value) > MAX;
    end else if (cnt_q != '0) begin
      {bcd_q, bin_q} <= {adj, bin_q} << 1;
      cnt_q          <= cnt_q - 1'b1;
    end
  end

  assign done     = (cnt_q == '0) && !start;
  assign bcd      = bcd_q;
  assign overflow = ovf_q;

endmodule

// File: rtl/lcd_status_display.sv
// Draws "Cmd:X B:<dir> D:<dist>" on a 16x2 LCD through an Avalon-MM write stream,
// redrawing on refresh or on input change, with abort-and-retry on error responses.
module lcd_status_display
  import lcd_pkg::*;
#(
  parameter int unsigned CMD_W       = 3,
  parameter int unsigned CMD_MAX     = 6,
  parameter int unsigned DIR_W       = 5,
  parameter int unsigned DIR_DIGITS  = 2,
  parameter int unsigned DIST_W      = 8,
  parameter int unsigned DIST_DIGITS = 3,
  parameter int unsigned AUTO_REDRAW = 1
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic [CMD_W-1:0]      command,
  input  logic [DIR_W-1:0]      direction,
  input  logic [DIST_W-1:0]     distance,
  input  logic                  refresh,
  lcd_status_display_if.master  av,
  output logic                  busy,
  output logic                  frame_done,
  output logic                  error
);

  localparam int unsigned FRAME_LEN = 13 + DIR_DIGITS + DIST_DIGITS;
  localparam int unsigned IDX_W     = $clog2(FRAME_LEN);
  localparam int          DD        = int'(DIR_DIGITS);
  localparam int          SD        = int'(DIST_DIGITS);

  state_e                   state_q;
  logic [CMD_W-1:0]         cmd_q;
  logic [DIR_W-1:0]         dir_q;
  logic [DIST_W-1:0]        dist_q;
  logic                     valid_q, pending_q, conv_start_q;
  logic                     write_q, addr_q, busy_q, frame_done_q, error_q;
  logic [7:0]               data_q;
  logic [IDX_W-1:0]         idx_q, nxt_idx;
  logic                     nxt_addr;
  logic [7:0]               nxt_data, cmd_char;
  logic [4*DIR_DIGITS-1:0]  dir_bcd;
  logic [4*DIST_DIGITS-1:0] dist_bcd;
  logic                     dir_done, dist_done, dir_ovf, dist_ovf;
  logic                     changed, trigger, accept;
  int                       k;

  lcd_bin2bcd #(.W(DIR_W), .DIGITS(DIR_DIGITS)) u_dir_conv (
    .clk      (clk),
    .reset_n  (reset_n),
    .start    (conv_start_q),
    .value    (dir_q),
    .done     (dir_done),
    .bcd      (dir_bcd),
    .overflow (dir_ovf)
  );

  lcd_bin2bcd #(.W(DIST_W), .DIGITS(DIST_DIGITS)) u_dist_conv (
    .clk      (clk),
    .reset_n  (reset_n),
    .start    (conv_start_q),
    .value    (dist_q),
    .done     (dist_done),
    .bcd      (dist_bcd),
    .overflow (dist_ovf)
  );

  assign changed  = (command != cmd_q) || (direction != dir_q) || (distance != dist_q);
  assign trigger  = refresh || pending_q || !valid_q || ((AUTO_REDRAW != 0) && changed);
  assign accept   = write_q && !av.waitrequest;
  assign cmd_char = (32'(cmd_q) <= CMD_MAX) ? CHR_0 + 8'(cmd_q) : CHR_HASH;

  // Item nxt_idx of the frame: two instructions, then the character string.
  always_comb begin
    nxt_idx  = (state_q == StConvert) ? '0 : idx_q + 1'b1;
    k        = int'(nxt_idx) - 2;
    nxt_addr = 1'b1;
    nxt_data = CHR_SPACE;
    if (nxt_idx == '0) begin
      nxt_addr = 1'b0;
      nxt_data = CLEAR_DISPLAY;
    end else if (nxt_idx == IDX_W'(1)) begin
      nxt_addr = 1'b0;
      nxt_data = CURSOR_OFF;
    end else if (k == 0) nxt_data = CHR_C;
    else if (k == 1) nxt_data = CHR_LOWER_M;
    else if (k == 2) nxt_data = CHR_LOWER_D;
    else if (k == 3) nxt_data = CHR_COLON;
    else if (k == 4) nxt_data = cmd_char;
    else if (k == 5) nxt_data = CHR_SPACE;
    else if (k == 6) nxt_data = CHR_B;
    else if (k == 7) nxt_data = CHR_COLON;
    else if (k < 8 + DD) begin
      nxt_data = dir_ovf ? CHR_HASH : digit_char(4'(dir_bcd >> (4 * (DD + 7 - k))));
    end else if (k == 8 + DD) nxt_data = CHR_SPACE;
    else if (k == 9 + DD) nxt_data = CHR_D;
    else if (k == 10 + DD) nxt_data = CHR_COLON;
    else begin
      nxt_data = dist_ovf ? CHR_HASH : digit_char(4'(dist_bcd >> (4 * (SD + DD + 10 - k))));
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= StIdle;
      cmd_q        <= '0;
      dir_q        <= '0;
      dist_q       <= '0;
      valid_q      <= 1'b0;
      pending_q    <= 1'b0;
      conv_start_q <= 1'b0;
      write_q      <= 1'b0;
      addr_q       <= 1'b0;
      data_q       <= '0;
      idx_q        <= '0;
      busy_q       <= 1'b0;
      frame_done_q <= 1'b0;
      error_q      <= 1'b0;
    end else begin
      frame_done_q <= 1'b0;
      conv_start_q <= 1'b0;
      if (refresh && state_q != StIdle) pending_q <= 1'b1;
      unique case (state_q)
        StIdle: begin
          if (trigger) begin
            cmd_q        <= command;
            dir_q        <= direction;
            dist_q       <= distance;
            valid_q      <= 1'b1;
            pending_q    <= 1'b0;
            busy_q       <= 1'b1;
            conv_start_q <= 1'b1;
            state_q      <= StConvert;
          end
        end
        StConvert: begin
          if (!conv_start_q && dir_done && dist_done) begin
            write_q <= 1'b1;
            addr_q  <= nxt_addr;
            data_q  <= nxt_data;
            idx_q   <= nxt_idx;
            state_q <= StClear;
          end
        end
        StClear, StCursor, StChars: begin
          if (accept) begin
            if (av.response != 2'b00) begin
              // Retry the whole frame from the same snapshot.
              error_q      <= 1'b1;
              write_q      <= 1'b0;
              conv_start_q <= 1'b1;
              state_q      <= StConvert;
            end else if (idx_q == IDX_W'(FRAME_LEN - 1)) begin
              write_q      <= 1'b0;
              busy_q       <= 1'b0;
              frame_done_q <= 1'b1;
              state_q      <= StDone;
            end else begin
              idx_q   <= nxt_idx;
              addr_q  <= nxt_addr;
              data_q  <= nxt_data;
              state_q <= (nxt_idx == IDX_W'(1)) ? StCursor : StChars;
            end
          end
        end
        StDone:  state_q <= StIdle;
        default: state_q <= StIdle;
      endcase
    end
  end

  logic unused_readdata;
  assign unused_readdata = ^av.readdata;

  assign av.address    = addr_q;
  assign av.chipselect = write_q;
  assign av.byteenable = write_q;
  assign av.read       = 1'b0;
  assign av.write      = write_q;
  assign av.writedata  = data_q;
  assign busy          = busy_q;
  assign frame_done    = frame_done_q;
  assign error         = error_q;

endmodule

// File: tb/tb_lcd_status_display.sv
// Directed bench for lcd_status_display: a slave model logs accepted writes and
// frames are compared against strings built independently from the inputs.
module tb_lcd_status_display;

  logic       clk;
  logic       reset_n;
  logic [2:0] command;
  logic [4:0] direction;
  logic [7:0] distance;
  logic       refresh;
  logic       busy, frame_done, error;

  lcd_status_display_if av ();

  lcd_status_display dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .command    (command),
    .direction  (direction),
    .distance   (distance),
    .refresh    (refresh),
    .av         (av),
    .busy       (busy),
    .frame_done (frame_done),
    .error      (error)
  );

  assign av.readdata = 8'h00;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int          n_checks = 0;
  int          n_errors = 0;
  int          cyc = 0;
  int          done_cnt = 0;
  int          stall_bad = 0;
  int          proto_bad = 0;
  int          busy_bad = 0;
  int          n_stalls = 0;
  int          max_stall = 0;
  int          stall_left = 0;
  int          err_at = 0;
  logic        stalled = 1'b0;
  logic [8:0]  held;
  logic [8:0]  log_q[$];
  int          acc_q[$];

  always @(posedge clk) cyc <= cyc + 1;

  // Slave model: decides waitrequest/response for the coming edge and logs accepted writes.
  always @(negedge clk) begin
    if (!reset_n) begin
      av.waitrequest = 1'b0;
      av.response    = 2'b00;
      stalled        = 1'b0;
    end else begin
      if (av.chipselect !== av.write || av.byteenable !== av.write || av.read !== 1'b0)
        proto_bad++;
      if (stalled && (av.write !== 1'b1 || {av.address, av.writedata} !== held)) stall_bad++;
      if (av.write === 1'b1 && busy !== 1'b1) busy_bad++;
      if (frame_done === 1'b1) begin
        done_cnt++;
        if (busy !== 1'b0) busy_bad++;
      end
      stalled        = 1'b0;
      av.waitrequest = 1'b0;
      av.response    = 2'b00;
      if (av.write === 1'b1) begin
        if (stall_left > 0) begin
          stall_left--;
          av.waitrequest = 1'b1;
          stalled        = 1'b1;
          held           = {av.address, av.writedata};
          n_stalls++;
        end else begin
          if (err_at != 0 && log_q.size() + 1 == err_at) av.response = 2'b10;
          log_q.push_back({av.address, av.writedata});
          acc_q.push_back(cyc);
          stall_left = (max_stall > 0) ? int'($urandom_range(max_stall, 0)) : 0;
        end
      end
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_log();
    log_q.delete();
    acc_q.delete();
  endtask

  task automatic pulse_refresh();
    refresh = 1'b1;
    tick();
    refresh = 1'b0;
  endtask

  task automatic wait_frames(input int target, input string tag);
    int n = 0;
    while (done_cnt < target && n < 3000) begin
      tick();
      n++;
    end
    check({tag, "_done"}, 32'(done_cnt >= target), 32'd1);
  endtask

  task automatic wait_writes(input int target, input string tag);
    int n = 0;
    while (log_q.size() < target && n < 3000) begin
      tick();
      n++;
    end
    check({tag, "_writes"}, 32'(log_q.size() >= target), 32'd1);
  endtask

  // Expected log: optional aborted prefix of the frame, then the full frame.
  task automatic check_frame(input string tag, input int c, input int d, input int s,
                             input int prefix);
    logic [8:0] f[$];
    logic [8:0] e[$];
    string      txt;
    txt = "Cmd:";
    if (c <= 6) txt = {txt, $sformatf("%0d", c)};
    else txt = {txt, "#"};
    txt = {txt, " B:"};
    if (d > 99) txt = {txt, "##"};
    else txt = {txt, $sformatf("%02d", d)};
    txt = {txt, " D:"};
    if (s > 999) txt = {txt, "###"};
    else txt = {txt, $sformatf("%03d", s)};
    f.push_back(9'h001);
    f.push_back(9'h00C);
    for (int i = 0; i < txt.len(); i++) f.push_back({1'b1, txt[i]});
    for (int i = 0; i < prefix; i++) e.push_back(f[i]);
    for (int i = 0; i < f.size(); i++) e.push_back(f[i]);
    check({tag, "_len"}, 32'(log_q.size()), 32'(e.size()));
    for (int i = 0; i < e.size() && i < log_q.size(); i++)
      check($sformatf("%s_w%0d", tag, i), 32'(log_q[i]), 32'(e[i]));
  endtask

  function automatic int span();
    return (acc_q.size() > 0) ? acc_q[acc_q.size() - 1] - acc_q[0] : -1;
  endfunction

  int base;

  initial begin
    reset_n   = 1'b0;
    command   = 3'd0;
    direction = 5'd0;
    distance  = 8'd0;
    refresh   = 1'b0;
    repeat (3) tick();
    check("rst_write", 32'(av.write), 32'd0);
    check("rst_chipselect", 32'(av.chipselect), 32'd0);
    check("rst_writedata", 32'(av.writedata), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_frame_done", 32'(frame_done), 32'd0);
    check("rst_error", 32'(error), 32'd0);
    clear_log();
    reset_n = 1'b1;

    // 1: invalid snapshot draws the all-zero frame right after reset.
    wait_frames(1, "t1");
    check_frame("t1", 0, 0, 0, 0);
    check("t1_span", 32'(span()), 32'd17);
    check("t1_error", 32'(error), 32'd0);

    // 2: input change triggers a redraw, back-to-back writes.
    clear_log();
    base      = done_cnt;
    command   = 3'd3;
    direction = 5'd12;
    distance  = 8'd89;
    wait_frames(base + 1, "t2");
    check_frame("t2", 3, 12, 89, 0);
    check("t2_span", 32'(span()), 32'd17);

    // 3: command above CMD_MAX is drawn as '#'.
    clear_log();
    base      = done_cnt;
    command   = 3'd7;
    direction = 5'd31;
    distance  = 8'd255;
    wait_frames(base + 1, "t3");
    check_frame("t3", 7, 31, 255, 0);

    // 4: random stalls, refresh-triggered redraw of the same values.
    clear_log();
    base       = done_cnt;
    max_stall  = 5;
    stall_left = int'($urandom_range(5, 0));
    n_stalls   = 0;
    pulse_refresh();
    wait_frames(base + 1, "t4");
    check_frame("t4", 7, 31, 255, 0);
    check("t4_stable", 32'(stall_bad), 32'd0);
    check("t4_stalled", 32'(n_stalls > 0), 32'd1);
    max_stall  = 0;
    stall_left = 0;

    // 5: error response on the 7th write aborts and restarts the frame.
    clear_log();
    base      = done_cnt;
    err_at    = 7;
    command   = 3'd1;
    direction = 5'd5;
    distance  = 8'd200;
    wait_frames(base + 1, "t5");
    check_frame("t5", 1, 5, 200, 7);
    check("t5_error", 32'(error), 32'd1);
    err_at = 0;

    // 6: mid-frame input change is deferred to a second frame.
    clear_log();
    base     = done_cnt;
    distance = 8'd10;
    wait_writes(5, "t6");
    distance = 8'd11;
    wait_frames(base + 1, "t6a");
    check_frame("t6a", 1, 5, 10, 0);
    clear_log();
    wait_frames(base + 2, "t6b");
    check_frame("t6b", 1, 5, 11, 0);
    check("t6_error_sticky", 32'(error), 32'd1);

    // 7: two refresh pulses during a frame queue exactly one redraw.
    clear_log();
    base = done_cnt;
    pulse_refresh();
    wait_writes(3, "t7");
    pulse_refresh();
    tick();
    pulse_refresh();
    wait_frames(base + 2, "t7");
    repeat (100) tick();
    check("t7_frames", 32'(done_cnt), 32'(base + 2));

    // 8: reset mid-frame drops write at once; a fresh frame follows.
    clear_log();
    pulse_refresh();
    wait_writes(5, "t8");
    check("t8_write_before", 32'(av.write), 32'd1);
    #1;
    reset_n = 1'b0;
    #1;
    check("t8_rst_write", 32'(av.write), 32'd0);
    check("t8_rst_busy", 32'(busy), 32'd0);
    check("t8_rst_error", 32'(error), 32'd0);
    tick();
    clear_log();
    base    = done_cnt;
    reset_n = 1'b1;
    wait_frames(base + 1, "t8");
    check_frame("t8", 1, 5, 11, 0);
    check("t8_error", 32'(error), 32'd0);

    check("proto", 32'(proto_bad), 32'd0);
    check("busy_flag", 32'(busy_bad), 32'd0);
    check("stall_stable", 32'(stall_bad), 32'd0);
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
